// File: rtl/ecc_result_collector.sv
// ecc_result_collector
// Collects results from the ECC encode/decode core into a first-word-fall-through
// FIFO and keeps error-class statistics with sticky overflow/illegal-code flags.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   data_out        - core result data (sampled when operation_done=1)
//   operation_done  - 1-cycle result-valid pulse
//   num_of_errors   - 00 none, 01 single, 10 double, 11 illegal
//   rd_en           - pop head entry (ignored while empty)
//   clear_stats     - clears counters and sticky flags
//   rd_valid        - FIFO not empty
//   rd_data         - head data (FWFT), 0 while empty
//   rd_errors       - head error code, 0 while empty
//   full, level     - occupancy status
//   overflow        - sticky: a result was dropped
//   illegal_code    - sticky: code 11 seen
//   cnt_total/cnt_single/cnt_double - saturating statistics counters
module ecc_result_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    data_out,
  input  logic                     operation_done,
  input  logic [1:0]               num_of_errors,
  input  logic                     rd_en,
  input  logic                     clear_stats,
  output logic                     rd_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic [1:0]               rd_errors,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     illegal_code,
  output logic [CNT_WIDTH-1:0]     cnt_total,
  output logic [CNT_WIDTH-1:0]     cnt_single,
  output logic [CNT_WIDTH-1:0]     cnt_double
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_WIDTH + 2;

  logic [EW-1:0]        mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 overflow_q, overflow_d;
  logic                 illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0] cnt_total_q, cnt_total_d;
  logic [CNT_WIDTH-1:0] cnt_single_q, cnt_single_d;
  logic [CNT_WIDTH-1:0] cnt_double_q, cnt_double_d;

  logic          pop, push, dropped;
  logic [EW-1:0] head;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign pop     = rd_en && (level_q != '0);
  assign push    = operation_done && ((level_q != LW'(DEPTH)) || pop);
  assign dropped = operation_done && !push;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    illegal_d    = illegal_q;
    cnt_total_d  = cnt_total_q;
    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // clear_stats wins over a same-cycle result: it is queued but not counted.
    if (clear_stats) begin
      overflow_d   = 1'b0;
      illegal_d    = 1'b0;
      cnt_total_d  = '0;
      cnt_single_d = '0;
      cnt_double_d = '0;
    end else if (operation_done) begin
      cnt_total_d = sat_inc(cnt_total_q);
      if (num_of_errors == 2'b01) cnt_single_d = sat_inc(cnt_single_q);
      if (num_of_errors[1])       cnt_double_d = sat_inc(cnt_double_q);
      if (num_of_errors == 2'b11) illegal_d    = 1'b1;
      if (dropped)                overflow_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      illegal_q    <= 1'b0;
      cnt_total_q  <= '0;
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      illegal_q    <= illegal_d;
      cnt_total_q  <= cnt_total_d;
      cnt_single_q <= cnt_single_d;
      cnt_double_q <= cnt_double_d;
    end
  end

  // Storage needs no reset: contents are only visible while level is non-zero.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= {num_of_errors, data_out};
  end

  assign head         = mem_q[rd_ptr_q];
  assign rd_valid     = (level_q != '0);
  assign rd_data      = rd_valid ? head[DATA_WIDTH-1:0] : '0;
  assign rd_errors    = rd_valid ? head[EW-1:DATA_WIDTH] : 2'b00;
  assign full         = (level_q == LW'(DEPTH));
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign illegal_code = illegal_q;
  assign cnt_total    = cnt_total_q;
  assign cnt_single   = cnt_single_q;
  assign cnt_double   = cnt_double_q;

endmodule

// File: tb/tb_ecc_result_collector.sv
module tb_ecc_result_collector;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] data_out = '0;
  logic          operation_done = 1'b0;
  logic [1:0]    num_of_errors = 2'b00;
  logic          rd_en = 1'b0;
  logic          clear_stats = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_errors;
  logic          full;
  logic [3:0]    level;
  logic          overflow;
  logic          illegal_code;
  logic [CW-1:0] cnt_total, cnt_single, cnt_double;

  ecc_result_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .data_out(data_out), .operation_done(operation_done),
    .num_of_errors(num_of_errors), .rd_en(rd_en), .clear_stats(clear_stats),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_errors(rd_errors), .full(full),
    .level(level), .overflow(overflow), .illegal_code(illegal_code),
    .cnt_total(cnt_total), .cnt_single(cnt_single), .cnt_double(cnt_double)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of {code, data} plus plain integer statistics.
  logic [DW+1:0] mq[$];
  int  m_tot, m_sgl, m_dbl;
  bit  m_ovf, m_ill;
  int  n_cmp = 0;
  int  n_err = 0;
  logic [DW-1:0] last_pop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [DW+1:0] h;
    h = (mq.size() != 0) ? mq[0] : '0;
    chk("rd_valid",     64'(rd_valid),     64'(mq.size() != 0));
    chk("rd_data",      64'(rd_data),      64'(h[DW-1:0]));
    chk("rd_errors",    64'(rd_errors),    64'(h[DW+1:DW]));
    chk("full",         64'(full),         64'(mq.size() == DEPTH));
    chk("level",        64'(level),        64'(mq.size()));
    chk("overflow",     64'(overflow),     64'(m_ovf));
    chk("illegal_code", 64'(illegal_code), 64'(m_ill));
    chk("cnt_total",    64'(cnt_total),    64'(m_tot));
    chk("cnt_single",   64'(cnt_single),   64'(m_sgl));
    chk("cnt_double",   64'(cnt_double),   64'(m_dbl));
  endtask

  task automatic step(input bit op, input logic [DW-1:0] d, input logic [1:0] code,
                      input bit rd, input bit clr);
    bit do_pop, do_push;
    operation_done = op; data_out = d; num_of_errors = code;
    rd_en = rd; clear_stats = clr;
    @(posedge clk);
    do_pop  = rd && (mq.size() > 0);
    do_push = op && ((mq.size() < DEPTH) || do_pop);
    if (do_pop) last_pop = mq.pop_front();
    if (do_push) mq.push_back({code, d});
    if (clr) begin
      m_tot = 0; m_sgl = 0; m_dbl = 0; m_ovf = 0; m_ill = 0;
    end else if (op) begin
      if (m_tot < MAXC) m_tot++;
      if (code == 2'b01 && m_sgl < MAXC) m_sgl++;
      if (code[1] && m_dbl < MAXC) m_dbl++;
      if (code == 2'b11) m_ill = 1;
      if (!do_push) m_ovf = 1;
    end
    #1;
    check_all();
  endtask

  task automatic do_reset(input bit op);
    rst = 1'b1; operation_done = op; rd_en = 1'b0; clear_stats = 1'b0;
    data_out = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    rst = 1'b0; operation_done = 1'b0;
    mq.delete();
    m_tot = 0; m_sgl = 0; m_dbl = 0; m_ovf = 0; m_ill = 0;
    check_all();
  endtask

  initial begin
    // 1: three results, read back in order
    do_reset(1'b0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    step(1, 32'hA5A5A5A5, 2'b00, 0, 0);
    chk("t1_first_head", 64'(rd_data), 64'hA5A5A5A5);
    step(1, 32'h0000FFFF, 2'b01, 0, 0);
    step(1, 32'h12345678, 2'b10, 0, 0);
    chk("t1_level", 64'(level), 64'd3);
    chk("t1_total", 64'(cnt_total), 64'd3);
    chk("t1_single", 64'(cnt_single), 64'd1);
    chk("t1_double", 64'(cnt_double), 64'd1);
    step(0, 0, 0, 1, 0); chk("t1_pop0", 64'(last_pop[DW-1:0]), 64'hA5A5A5A5);
    step(0, 0, 0, 1, 0); chk("t1_pop1", 64'(last_pop[DW-1:0]), 64'h0000FFFF);
    step(0, 0, 0, 1, 0); chk("t1_pop2", 64'(last_pop[DW-1:0]), 64'h12345678);

    // 2: DEPTH+2 pushes, no pops
    do_reset(1'b0);
    for (int i = 0; i < DEPTH + 2; i++) step(1, 32'h100 + i, 2'b00, 0, 0);
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_level", 64'(level), 64'd8);
    chk("t2_overflow", 64'(overflow), 64'd1);
    chk("t2_total", 64'(cnt_total), 64'd10);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 1, 0);
      chk("t2_drain", 64'(last_pop[DW-1:0]), 64'(32'h100 + i));
    end
    chk("t2_empty", 64'(rd_valid), 64'd0);

    // 3: full + push + pop
    do_reset(1'b0);
    for (int i = 0; i < DEPTH; i++) step(1, 32'h200 + i, 2'b01, 0, 0);
    step(1, 32'hCAFE0003, 2'b10, 1, 0);
    chk("t3_level", 64'(level), 64'd8);
    chk("t3_overflow", 64'(overflow), 64'd0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0);
    chk("t3_tail", 64'(last_pop[DW-1:0]), 64'hCAFE0003);

    // 4: rd_en on empty, then push with rd_en
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0);
      chk("t4_valid", 64'(rd_valid), 64'd0);
      chk("t4_level", 64'(level), 64'd0);
    end
    step(1, 32'h44444444, 2'b00, 1, 0);
    chk("t4_push_valid", 64'(rd_valid), 64'd1);
    chk("t4_push_data", 64'(rd_data), 64'h44444444);

    // 5: illegal code, then clear with simultaneous push
    step(1, 32'h55555555, 2'b11, 0, 0);
    chk("t5_illegal", 64'(illegal_code), 64'd1);
    chk("t5_double", 64'(cnt_double), 64'd2);
    step(1, 32'h66666666, 2'b11, 0, 1);
    chk("t5_clr_total", 64'(cnt_total), 64'd0);
    chk("t5_clr_ill", 64'(illegal_code), 64'd0);
    chk("t5_clr_level", 64'(level), 64'd3);

    // Randomized traffic with varying read pressure
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 400; i++)
        step($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)),
             $urandom_range(0, 9) < (2 + ph * 3), $urandom_range(0, 39) == 0);
    end

    // 6: saturation, then reset while busy
    do_reset(1'b0);
    for (int i = 0; i < 65537; i++)
      step(1, $urandom, 2'b01, $urandom_range(0, 1) == 1, 0);
    chk("t6_single_sat", 64'(cnt_single), 64'hFFFF);
    chk("t6_total_sat", 64'(cnt_total), 64'hFFFF);
    step(1, $urandom, 2'b01, 0, 0);
    chk("t6_single_hold", 64'(cnt_single), 64'hFFFF);
    do_reset(1'b1);
    chk("t6_rst_level", 64'(level), 64'd0);
    chk("t6_rst_valid", 64'(rd_valid), 64'd0);
    chk("t6_rst_single", 64'(cnt_single), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
